// File: rtl/thumb_fetch_pkg.sv
// ----------------------------------------------------------------------------
// thumb_fetch_pkg
// Shared types for the Thumb instruction fetch stage.
//   halfword_t       : one 16-bit Thumb instruction
//   fetch_entry_t    : prefetch FIFO entry {instr, pc}
//   RESET_PC_DEFAULT : byte address fetched first after reset
//   fetch_state_t    : fetch control states BOOT / RUN / FLUSH
//   select_halfword  : picks the low or high halfword of a memory word
// ----------------------------------------------------------------------------
package thumb_fetch_pkg;

    typedef logic [15:0] halfword_t;

    typedef struct packed {
        halfword_t   instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    // Little-endian halfword select: byte address bit 1 picks the upper half.
    function automatic halfword_t select_halfword(input logic [31:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Prefetch FIFO of fetch_entry_t with synchronous clear and an occupancy count.
// Build option: THUMB_FETCH_PAIR_EN adds a second push lane (push1_*) so one
// memory word can enqueue two halfwords in a single cycle; without it the
// push port is a single entry.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   clear                 : synchronous flush (drops all entries)
//   push0_en/push0_data   : first (or only) push lane
//   push1_en/push1_data   : second push lane, honoured only with push0_en
//   pop_en                : consume the head entry (ignored when empty)
//   head, empty, count    : head entry, empty flag, occupancy
// ----------------------------------------------------------------------------
module fetch_fifo
    import thumb_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push0_en,
    input  fetch_entry_t             push0_data,
`ifdef THUMB_FETCH_PAIR_EN
    input  logic                     push1_en,
    input  fetch_entry_t             push1_data,
`endif
    input  logic                     pop_en,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   entries_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  wr_ptr_plus1;
    logic [PW:0]    count_q, count_d;
    logic [PW:0]    push_cnt;
    logic           pop_ok;

    assign pop_ok       = pop_en && (count_q != '0);
    assign wr_ptr_plus1 = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};

    always_comb begin
        push_cnt = {{PW{1'b0}}, push0_en};
`ifdef THUMB_FETCH_PAIR_EN
        push_cnt = push_cnt + {{PW{1'b0}}, push0_en && push1_en};
`endif
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Push and pop in the same cycle both land; count nets out.
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop_ok};
            wr_ptr_d = wr_ptr_q + push_cnt[PW-1:0];
            count_d  = count_q + push_cnt - {{PW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clock) begin
        if (push0_en) begin
            entries_q[wr_ptr_q] <= push0_data;
        end
`ifdef THUMB_FETCH_PAIR_EN
        if (push0_en && push1_en) begin
            entries_q[wr_ptr_plus1] <= push1_data;
        end
`endif
    end

    assign head  = entries_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/thumb_fetch.sv
// ----------------------------------------------------------------------------
// thumb_fetch
// Thumb instruction fetch stage: requests 32-bit words from word-addressed
// memory, splits them into halfwords, buffers them in a prefetch FIFO and
// presents one instruction per cycle to decode over valid/ready. A redirect
// flushes everything (including an outstanding read) and restarts fetch.
// Build option: THUMB_FETCH_PAIR_EN -- one word request may yield two
// halfwords and fetch_pc advances by a word; otherwise each request yields
// one halfword and fetch_pc advances by 2.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   mem_req, mem_addr, mem_rdata : memory read port (data one cycle later)
//   redirect, redirect_pc        : taken branch, new byte PC (bit 0 forced 0)
//   instr, instr_pc, instr_valid : FIFO head presented to decode
//   instr_ready                  : decode accepts the head this cycle
// ----------------------------------------------------------------------------
module thumb_fetch
    import thumb_fetch_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [15:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         inflight_q, inflight_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    fetch_entry_t  fifo_head;
    logic [CW+1:0] committed;
    logic          issue;
    logic          pop;
    logic          push0_en;
    fetch_entry_t  push0_data;
`ifdef THUMB_FETCH_PAIR_EN
    logic          push1_en;
    fetch_entry_t  push1_data;
`endif

    // Slots already spoken for: occupied entries plus two reserved for an
    // outstanding read. Registered values only -- a same-cycle pop does not
    // free space for this cycle's request.
    assign committed = {2'b00, fifo_count} + {{CW{1'b0}}, inflight_q, 1'b0};
    assign issue     = (state_q == ST_RUN) && !redirect &&
                       ((committed + (CW+2)'(2)) <= (CW+2)'(FIFO_DEPTH));

    // A read response is always consumed the cycle after its request, unless
    // a redirect in that cycle discards it.
    assign push0_en   = inflight_q && !redirect;
    assign push0_data = '{instr: select_halfword(mem_rdata, inflight_pc_q[1]),
                          pc:    inflight_pc_q};
`ifdef THUMB_FETCH_PAIR_EN
    // Word-aligned request: the upper halfword follows as a second entry.
    assign push1_en   = push0_en && !inflight_pc_q[1];
    assign push1_data = '{instr: mem_rdata[31:16], pc: inflight_pc_q + 32'd2};
`endif

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect) begin
            state_d    = ST_FLUSH;
            fetch_pc_d = redirect_pc & ~32'd1;
        end else begin
            // BOOT and FLUSH each last one idle cycle; RUN stays in RUN.
            state_d = ST_RUN;
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
`ifdef THUMB_FETCH_PAIR_EN
                fetch_pc_d    = (fetch_pc_q & ~32'd3) + 32'd4;
`else
                fetch_pc_d    = fetch_pc_q + 32'd2;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Redirect clears the FIFO; a handshake in that cycle is simply absorbed.
    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .clear      (redirect),
        .push0_en   (push0_en),
        .push0_data (push0_data),
`ifdef THUMB_FETCH_PAIR_EN
        .push1_en   (push1_en),
        .push1_data (push1_data),
`endif
        .pop_en     (pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;
    // Stale storage is masked so an empty FIFO presents zeros.
    assign instr       = instr_valid ? fifo_head.instr : 16'h0000;
    assign instr_pc    = instr_valid ? fifo_head.pc : 32'd0;
    assign mem_req     = issue;
    assign mem_addr    = fetch_pc_q[ADDR_W+1:2];

endmodule
